instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 105 ++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Immediate-format instruction encoder (I/S/B) behind a single-entry output register.
// Also counts accepted requests and requests whose immediate did not fit.
module instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ImmSrc,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr_out,
  output logic             imm_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [7:0]       err_count,
  output logic             fsm_state
);

  // Handshake: a word moves on any rising edge where valid && ready on that side.
  // in_ready depends only on the output side, never on in_valid.

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [31:0]       instr_q;
  logic              err_q;
  logic [CNT_W-1:0]  enc_count_q;
  logic [7:0]        err_count_q;
  logic              accept;
  logic [31:0]       enc_word;
  logic              enc_err;
  logic              i_fit;
  logic              b_fit;

  assign out_valid = (state_q == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign fsm_state = state_q;
  assign instr_out = instr_q;
  assign imm_err   = err_q;
  assign enc_count = enc_count_q;
  assign err_count = err_count_q;

  // Representable when all bits above the sign bit replicate it.
  assign i_fit = (&imm[31:11]) || !(|imm[31:11]);
  assign b_fit = (&imm[31:12]) || !(|imm[31:12]);

  always_comb begin
    enc_word = 32'h0;
    enc_err  = 1'b0;
    case (ImmSrc)
      2'b00: begin
        enc_word = {imm[11:0], rs1, funct3, rd, opcode};
        enc_err  = !i_fit;
      end
      2'b01: begin
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_err  = !i_fit;
      end
      2'b10: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc_err  = !b_fit || imm[0];
      end
      default: begin
        enc_word = 32'h0;
        enc_err  = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (out_ready && !in_valid) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      instr_q     <= 32'h0;
      err_q       <= 1'b0;
      enc_count_q <= '0;
      err_count_q <= 8'h00;
    end else begin
      state_q <= state_d;
      if (accept) begin
        instr_q     <= enc_word;
        err_q       <= enc_err;
        enc_count_q <= enc_count_q + CNT_W'(1);
        if (enc_err && (err_count_q != 8'hFF)) err_count_q <= err_count_q + 8'd1;
      end
    end
  end

endmodule
